// File: rtl/obuf_drain.sv
// Snoops core writes into the OBUF ring and replays pending bytes as a valid/ready stream; snoop-to-valid 4 cycles, 1 byte per 3 cycles max.
// Holds the byte until tx_ready_i and waits in REQ while gnt_i is low; define OBUF_CRLF_EN to expand 'h0A into 'h0D,'h0A.
module obuf_drain #(
  parameter int OBUF  = 'h1400,
  parameter int DEPTH = 'h400,
  parameter int ASZ   = 17
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  input  logic                    dwe_i,
  input  logic [ASZ-1:0]          waddr_i,
  input  logic                    gnt_i,
  output logic                    req_o,
  output logic [ASZ-1:0]          addr_o,
  input  logic [7:0]              data_i,
  output logic [7:0]              tx_data_o,
  output logic                    tx_valid_o,
  input  logic                    tx_ready_i,
  output logic [$clog2(DEPTH):0]  level_o,
  output logic                    ovf_o
);

  localparam int OW = $clog2(DEPTH);
  localparam int PW = OW + 1;
  localparam logic [ASZ-1:0] BASE     = ASZ'(OBUF);
  localparam logic [PW-1:0]  FULL_LVL = PW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_CAP,
    S_HOLD
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [PW-1:0]  r_wptr;
  logic [PW-1:0]  r_rptr;
  logic [7:0]     r_hold;
  logic           r_ovf;
  logic [PW-1:0]  w_level;
  logic [ASZ-1:0] w_snoop_addr;
  logic           w_snoop;
  logic           w_full;
  logic           w_hs;
  logic           w_cap;
`ifdef OBUF_CRLF_EN
  logic           r_cr;
`endif

  // Extra pointer bit separates full (level == DEPTH) from empty.
  assign w_level      = r_wptr - r_rptr;
  assign w_full       = (w_level == FULL_LVL);
  assign w_snoop_addr = BASE + ASZ'(r_wptr[OW-1:0]);
  assign w_snoop      = dwe_i && (waddr_i == w_snoop_addr);
  assign w_hs         = tx_valid_o && tx_ready_i;
  assign w_cap        = (r_state == S_CAP);

  assign req_o      = (r_state == S_REQ);
  assign addr_o     = BASE + ASZ'(r_rptr[OW-1:0]);
  assign tx_valid_o = (r_state == S_HOLD);
  assign level_o    = w_level;
  assign ovf_o      = r_ovf;
`ifdef OBUF_CRLF_EN
  assign tx_data_o  = r_cr ? 8'h0D : r_hold;
`else
  assign tx_data_o  = r_hold;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_level != '0) w_next = S_REQ;
      S_REQ:  if (gnt_i) w_next = S_CAP;
      S_CAP:  w_next = S_HOLD;
      S_HOLD: begin
        if (w_hs) begin
`ifdef OBUF_CRLF_EN
          if (r_cr) w_next = S_HOLD;
          else if (w_level != '0) w_next = S_REQ;
          else w_next = S_IDLE;
`else
          if (w_level != '0) w_next = S_REQ;
          else w_next = S_IDLE;
`endif
        end
      end
      default: w_next = S_IDLE;
    endcase
    if (flush_i) w_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_hold  <= '0;
      r_ovf   <= 1'b0;
`ifdef OBUF_CRLF_EN
      r_cr    <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      if (w_snoop) begin
        if (!w_full) r_wptr <= r_wptr + PW'(1);
        else         r_ovf  <= 1'b1;
      end
      // Flush wins over capture: the in-flight read byte is dropped.
      if (flush_i) begin
        r_rptr <= r_wptr;
        r_hold <= '0;
        r_ovf  <= 1'b0;
`ifdef OBUF_CRLF_EN
        r_cr   <= 1'b0;
`endif
      end else if (w_cap) begin
        r_hold <= data_i;
        r_rptr <= r_rptr + PW'(1);
`ifdef OBUF_CRLF_EN
        r_cr   <= (data_i == 8'h0A);
`endif
      end
`ifdef OBUF_CRLF_EN
      else if (w_hs && r_cr) begin
        r_cr <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: doc/obuf_drain.md
Name: obuf_drain

Overview:
- Read-side companion to the eJ32 output path. The core writes result bytes into the OBUF window of the shared 8-bit memory; this block snoops those writes and tracks a ring-buffer write pointer.
- It reads the pending bytes back from memory in order and presents them as a valid/ready byte stream, for a UART transmitter or the bench console.
- Sits beside eJ32 on the mb8 memory bus. It reads only in cycles granted by the bus arbiter.

Parameters:
- OBUF, 'h1400, base byte address of the output ring buffer.
- DEPTH, 'h400, ring size in bytes; must be a power of 2.
- ASZ, 17, memory address width (128 KB spram8).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- flush_i  in  1  drop all pending bytes: rptr<=wptr, holding reg cleared.
- dwe_i  in  1  core write strobe (snooped).
- waddr_i  in  ASZ  core write address (snooped).
- gnt_i  in  1  bus free for this block this cycle.
- req_o  out  1  read request to arbiter.
- addr_o  out  ASZ  read address, OBUF + rptr.
- data_i  in  8  memory read data, valid one cycle after a granted request.
- tx_data_o  out  8  stream byte.
- tx_valid_o  out  1  stream byte valid.
- tx_ready_i  in  1  sink accepts byte.
- level_o  out  log2(DEPTH)+1  bytes pending (wptr - rptr).
- ovf_o  out  1  sticky overflow flag.

Behaviour:
- Pointers: wptr and rptr are log2(DEPTH)+1 bits. The extra bit distinguishes full from empty. Offsets wrap mod DEPTH.
- Snoop rule: in any cycle with dwe_i=1 and waddr_i == OBUF + wptr[low bits]:
  - if level_o < DEPTH: wptr++.
  - else: wptr holds and ovf_o <= 1.
  - Writes elsewhere, including other OBUF offsets, are ignored.
- FSM states: IDLE, REQ, CAP, HOLD.
  - IDLE: if level_o != 0 and no flush -> REQ.
  - REQ: req_o=1, addr_o=OBUF+rptr. If gnt_i=1 -> CAP; otherwise stay in REQ (req_o stays high, addr_o stable).
  - CAP: latch data_i into the holding register; rptr++ -> HOLD.
  - HOLD: tx_valid_o=1 and tx_data_o stable until the handshake. On tx_valid_o & tx_ready_i: if level_o != 0 -> REQ (back-to-back), else -> IDLE.
- Throughput: at most 1 byte per 3 cycles with gnt_i and tx_ready_i held high.
- Latency: a snooped write in cycle N, with bus granted and FSM idle, gives tx_valid_o high in cycle N+4.
- Simultaneous snoop write and CAP increment: both apply in the same cycle; level_o reflects both.
- flush_i:
  - Highest priority: rptr<=wptr, FSM->IDLE, tx_valid_o<=0. Any in-flight read data is discarded.
  - ovf_o is cleared only by rst or flush_i.
- Reset values:
  - wptr=rptr=0, FSM=IDLE.
  - req_o=0, addr_o=OBUF, tx_valid_o=0, tx_data_o=0, level_o=0, ovf_o=0.
  - Reset asserted mid-transfer drops the held byte with no handshake.
- Wrap-around: after offset DEPTH-1, addr_o returns to OBUF. Snoop matching wraps the same way.

Optional Feature:
- Macro: OBUF_CRLF_EN.
- Defined: when the latched byte is 'h0A, HOLD first presents 'h0D. After its handshake it presents 'h0A. rptr advances once per memory byte, so a line feed costs two handshakes.
- Not defined: bytes pass through unchanged; one handshake per byte.

Test Plan:
- After rst, core writes 'h48,'h49 to 'h1400,'h1401; gnt_i=1, tx_ready_i=1 -> stream 'h48 then 'h49, level_o 2->0, ovf_o=0.
- Write to 'h1405 while wptr=0 -> ignored; level_o stays 0, req_o never asserts.
- tx_ready_i=0 for 10 cycles with 3 bytes pending -> tx_valid_o held, tx_data_o stable, level_o=2 while the first byte is held. Release -> remaining bytes emitted in order.
- gnt_i=0 for 5 cycles while in REQ -> req_o=1 and addr_o constant throughout; read completes on the first grant.
- Fill DEPTH bytes, then write one more at the matching offset -> ovf_o=1, wptr unchanged. Drain -> 'h400 bytes returned, addresses wrap 'h17FF->'h1400. flush_i then clears ovf_o.
- With OBUF_CRLF_EN defined, write 'h41,'h0A -> stream 'h41,'h0D,'h0A. Without it -> 'h41,'h0A.
